// File: rtl/booth_mac_ctrl.sv
// booth_mac_ctrl: operand sequencer and dot-product accumulator wrapped around a
// 6-bit signed Booth multiplier. An operand pair is accepted over valid/ready.
// It drives M/Q/start to the multiplier and waits out the fixed multiplier
// latency. The 12-bit product is then sign-extended and added into acc. A pair
// flagged last makes the batch sum available over valid/ready.
// Optional feature: define BOOTH_MAC_SAT_EN to saturate acc on signed overflow
// instead of wrapping. out_ovf is sticky in both builds.
module booth_mac_ctrl #(
  parameter int ACC_W       = 16,
  parameter int MUL_LATENCY = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_a,
  input  logic [5:0]       in_b,
  input  logic             in_last,
  input  logic             clr,
  output logic [5:0]       mul_m,
  output logic [5:0]       mul_q,
  output logic             mul_start,
  input  logic [11:0]      mul_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  localparam int CNT_W = $clog2(MUL_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LATENCY - 1);
  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, ACC, OUT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_q;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] acc_nxt;
  logic             ovf_now;
  logic             take;

  assign take      = in_valid && in_ready;
  assign out_acc   = acc;
  assign out_ovf   = ovf;

  // Product extension, add and signed-overflow detection for the ACC cycle.
  // Overflow occurs when both operands have the same sign and the sum's sign differs.
  always_comb begin
    prod_ext = ACC_W'($signed(mul_result));
    sum      = acc + prod_ext;
    ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    acc_nxt  = sum;
`ifdef BOOTH_MAC_SAT_EN
    // On overflow the true sum has the operands' shared sign, so clamp toward it
    if (ovf_now) acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
`else
    // Wrap modulo 2^ACC_W; the saturation bounds are only used by the clamp build
    if (ovf_now && (ACC_MAX == ACC_MIN)) acc_nxt = sum;
`endif
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/strobe outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_start = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !clr;
        if (take) state_nxt = LAUNCH;
      end
      LAUNCH: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (cnt == CNT_W'(1)) state_nxt = ACC;
      ACC:  state_nxt = last_q ? OUT : IDLE;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand capture, latency counter, accumulator and sticky overflow
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mul_m  <= '0;
      mul_q  <= '0;
      last_q <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            acc <= '0;
            ovf <= 1'b0;
          end else if (in_valid) begin
            mul_m  <= in_a;
            mul_q  <= in_b;
            last_q <= in_last;
          end
        end
        LAUNCH: cnt <= CNT_LOAD;
        WAIT:   cnt <= cnt - CNT_W'(1);
        ACC: begin
          acc <= acc_nxt;
          ovf <= ovf | ovf_now;
        end
        OUT: begin
          if (out_ready) begin
            acc    <= '0;
            ovf    <= 1'b0;
            last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mac_ctrl.sv
// Bench for booth_mac_ctrl. It uses a behavioural multiplier with fixed latency
// and a transaction-level controller model that counts cycles since acceptance.
// A compare process checks every cycle against that model. Directed batches
// carry hand-computed literal sums.
module tb_booth_mac_ctrl;
  localparam int ACC_W = 16;
  localparam int L     = 8;
  localparam longint MAXV = (longint'(1) << (ACC_W-1)) - 1;
  localparam longint MINV = -(longint'(1) << (ACC_W-1));

  logic clk = 0, n_rst = 0;
  logic in_valid = 0, in_last = 0, clr = 0, out_ready = 0;
  logic [5:0] in_a = 0, in_b = 0;
  logic in_ready, mul_start, out_valid, out_ovf;
  logic [5:0] mul_m, mul_q;
  logic [11:0] mul_result;
  logic [ACC_W-1:0] out_acc;

  int total = 0, bad = 0;

  booth_mac_ctrl #(.ACC_W(ACC_W), .MUL_LATENCY(L)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .clr(clr),
    .mul_m(mul_m), .mul_q(mul_q), .mul_start(mul_start), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Multiplier: product appears in the L-th cycle after the edge sampling start
  int mcnt;
  logic signed [11:0] mprod;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mul_result <= '0; mcnt <= 0; mprod <= '0;
    end else if (mul_start) begin
      mcnt <= L - 1;
      mprod <= $signed(mul_m) * $signed(mul_q);
      mul_result <= 12'h5A5;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mul_result <= mprod;
    end
  end

  // Controller model: t counts edges since acceptance; t==0 launch, t==L add
  function automatic bit oor(input longint s);
    return (s > MAXV) || (s < MINV);
  endfunction
  function automatic longint fit(input longint s);
`ifdef BOOTH_MAC_SAT_EN
    if (s > MAXV) return MAXV;
    if (s < MINV) return MINV;
    return s;
`else
    if (s > MAXV) return s - (longint'(1) << ACC_W);
    if (s < MINV) return s + (longint'(1) << ACC_W);
    return s;
`endif
  endfunction

  bit busy, outp, cl, ovf_m;
  int t;
  logic [5:0] ca, cb;
  longint acc_m;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= 0; outp <= 0; t <= 0; ca <= 0; cb <= 0; cl <= 0; acc_m <= 0; ovf_m <= 0;
    end else if (outp) begin
      if (out_ready) begin outp <= 0; acc_m <= 0; ovf_m <= 0; end
    end else if (busy) begin
      if (t == L) begin
        acc_m <= fit(acc_m + longint'($signed(ca)) * longint'($signed(cb)));
        ovf_m <= ovf_m | oor(acc_m + longint'($signed(ca)) * longint'($signed(cb)));
        busy  <= 0;
        outp  <= cl;
      end else t <= t + 1;
    end else if (clr) begin
      acc_m <= 0; ovf_m <= 0;
    end else if (in_valid) begin
      busy <= 1; t <= 0; ca <= in_a; cb <= in_b; cl <= in_last;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    #1;
    if (n_rst) begin
      chk("in_ready",  in_ready,  !busy && !outp && !clr);
      chk("mul_start", mul_start, busy && t == 0);
      chk("out_valid", out_valid, outp);
      chk("mul_m",     mul_m,     ca);
      chk("mul_q",     mul_q,     cb);
      chk("out_acc",   $signed(out_acc), acc_m);
      chk("out_ovf",   out_ovf,   ovf_m);
    end
  end

  task automatic send_pair(input logic [5:0] a, input logic [5:0] b, input logic last);
    int n = 0;
    @(negedge clk); #2;
    while (!in_ready && n < 100) begin @(negedge clk); #2; n++; end
    if (n >= 100) chk("send_timeout", n, 0);
    in_valid = 1; in_a = a; in_b = b; in_last = last;
    @(negedge clk); #2;
    in_valid = 0; in_a = 6'h15; in_b = 6'h2A; in_last = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk); #2;
    while (!in_ready && n < 100) begin @(negedge clk); #2; n++; end
    if (n >= 100) chk("idle_timeout", n, 0);
  endtask

  task automatic wait_out(input longint exp_acc, input logic exp_ovf, input int hold);
    int n = 0;
    @(negedge clk); #2;
    while (!out_valid && n < 200) begin @(negedge clk); #2; n++; end
    if (n >= 200) chk("out_timeout", n, 0);
    chk("batch_acc", $signed(out_acc), exp_acc);
    chk("batch_ovf", out_ovf, exp_ovf);
    repeat (hold) begin
      @(negedge clk); #2;
      chk("bp_valid", out_valid, 1);
      chk("bp_acc",   $signed(out_acc), exp_acc);
      chk("bp_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk); #2;
    out_ready = 0;
    chk("post_out_valid", out_valid, 0);
    chk("post_out_acc",   $signed(out_acc), 0);
  endtask

  initial begin
    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_acc",   out_acc, 0);
    chk("rst_ovf",   out_ovf, 0);
    chk("rst_m",     mul_m, 0);
    chk("rst_ready", in_ready, 1);
    @(negedge clk); n_rst = 1;

    // Single pair 3 * -2
    send_pair(6'sd3, -6'sd2, 1);
    wait_out(-6, 0, 0);

    // Batch with in_valid noise while busy: -6 + 35 + 1024
    send_pair(6'sd3, -6'sd2, 0);
    in_valid = 1; repeat (3) @(negedge clk); #2; in_valid = 0;
    send_pair(6'sd5, 6'sd7, 0);
    send_pair(-6'sd32, -6'sd32, 1);
    wait_out(1053, 0, 0);

    // 32 x 1024 overflows a 16-bit accumulator on the last pair
    for (int i = 0; i < 32; i++) begin
      send_pair(-6'sd32, -6'sd32, i == 31);
      if (i == 30) begin
        wait_idle();
        chk("acc_31_pairs", $signed(out_acc), 31744);
      end
    end
`ifdef BOOTH_MAC_SAT_EN
    wait_out(32767, 1, 0);
`else
    wait_out(-32768, 1, 0);
`endif

    // Backpressure for 5 cycles, then a fresh batch
    send_pair(6'sd3, 6'sd4, 1);
    wait_out(12, 0, 5);
    send_pair(6'sd2, 6'sd2, 1);
    wait_out(4, 0, 0);

    // clr in IDLE blocks acceptance and clears the partial sum
    send_pair(6'sd5, 6'sd5, 0);
    wait_idle();
    chk("partial_25", $signed(out_acc), 25);
    clr = 1; in_valid = 1; in_a = 6'sd9; in_b = 6'sd9; in_last = 1;
    #1;
    chk("clr_ready", in_ready, 0);
    @(negedge clk); #2;
    clr = 0; in_valid = 0; in_last = 0;
    chk("clr_acc", $signed(out_acc), 0);
    send_pair(6'sd1, 6'sd1, 1);
    wait_out(1, 0, 0);

    // Reset while waiting on the multiplier
    send_pair(6'sd3, 6'sd3, 1);
    repeat (3) @(negedge clk);
    #3; n_rst = 0; #1;
    chk("arst_m",     mul_m, 0);
    chk("arst_q",     mul_q, 0);
    chk("arst_start", mul_start, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_acc",   out_acc, 0);
    chk("arst_ovf",   out_ovf, 0);
    @(negedge clk); n_rst = 1;
    send_pair(-6'sd1, -6'sd1, 1);
    wait_out(1, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=<200000", $time);
    $fatal(1, "timeout");
  end
endmodule
